// File: rtl/crib_matcher.sv
// Crib-dragging comparator: holds a DEPTH-letter crib, slides a DEPTH-letter window over a
// letter stream and reports per-window positional equality counts ordered against a threshold.
module crib_matcher #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 8,
   parameter int POS_W = 16,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   input  logic [CW-1:0]    thresh,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [CW-1:0]    eq_cnt,
   output logic             cnt_eq,
   output logic             cnt_gt,
   output logic             cnt_lt,
   output logic             no_conflict,
   output logic [POS_W-1:0] pos
);
   localparam int LW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_LOAD, S_FILL, S_RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] crib    [DEPTH];
   logic [WIDTH-1:0] window  [DEPTH];
   logic [WIDTH-1:0] shifted [DEPTH];
   logic [LW-1:0]    load_cnt;
   logic [LW-1:0]    fill_cnt;
   logic [POS_W-1:0] next_pos;
   logic [CW-1:0]    match_cnt;
   logic             in_acc;
   logic             res_fire;

   assign load_ready = (state == S_LOAD);
   assign in_ready   = (state == S_FILL) || (state == S_RUN);
   assign in_acc     = in_valid && in_ready;
   assign res_fire   = in_acc && ((state == S_RUN) || (fill_cnt == LW'(DEPTH - 1)));

   // Post-shift window and its positional match count against the crib.
   // NOTE: every variable written here is given a default first, so no latch is inferred.
   always_comb begin
      match_cnt = '0;
      for (int i = 0; i < DEPTH - 1; i++) shifted[i] = window[i+1];
      shifted[DEPTH-1] = in_data;
      for (int i = 0; i < DEPTH; i++) begin
         if (shifted[i] == crib[i]) match_cnt = match_cnt + CW'(1);
      end
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_LOAD;
         // NOTE: crib and window are small flop arrays, not RAM, so they take the async reset.
         for (int i = 0; i < DEPTH; i++) begin
            crib[i]   <= '0;
            window[i] <= '0;
         end
         load_cnt    <= '0;
         fill_cnt    <= '0;
         next_pos    <= '0;
         out_valid   <= 1'b0;
         eq_cnt      <= '0;
         cnt_eq      <= 1'b0;
         cnt_gt      <= 1'b0;
         cnt_lt      <= 1'b0;
         no_conflict <= 1'b0;
         pos         <= '0;
      end else begin
         out_valid <= 1'b0;
         if (clear) begin
            state    <= S_LOAD;
            load_cnt <= '0;
            fill_cnt <= '0;
            next_pos <= '0;
         end else begin
            case (state)
               S_LOAD: begin
                  if (load_valid) begin
                     crib[load_cnt] <= load_data;
                     if (load_cnt == LW'(DEPTH - 1)) begin
                        load_cnt <= '0;
                        state    <= S_FILL;
                     end else begin
                        load_cnt <= load_cnt + LW'(1);
                     end
                  end
               end
               S_FILL: begin
                  if (in_valid) begin
                     window <= shifted;
                     if (fill_cnt == LW'(DEPTH - 1)) begin
                        fill_cnt <= '0;
                        state    <= S_RUN;
                     end else begin
                        fill_cnt <= fill_cnt + LW'(1);
                     end
                  end
               end
               S_RUN: begin
                  if (in_valid) window <= shifted;
               end
               default: state <= S_LOAD;
            endcase

            // next_pos is the stream count minus DEPTH for the upcoming result; it saturates.
            if (res_fire) begin
               out_valid   <= 1'b1;
               eq_cnt      <= match_cnt;
               cnt_eq      <= (match_cnt == thresh);
               cnt_gt      <= (match_cnt > thresh);
               cnt_lt      <= (match_cnt < thresh);
               no_conflict <= (match_cnt == '0);
               pos         <= next_pos;
               if (next_pos != '1) next_pos <= next_pos + POS_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_crib_matcher.sv
// Directed self-checking bench for crib_matcher with DEPTH=4 and a 3-bit POS so that
// saturation is reachable in a short run.
module tb_crib_matcher;
   localparam int WIDTH = 5;
   localparam int DEPTH = 4;
   localparam int POS_W = 3;
   localparam int CW    = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             clear = 1'b0;
   logic             load_valid = 1'b0;
   logic [WIDTH-1:0] load_data = '0;
   logic             load_ready;
   logic [CW-1:0]    thresh = '0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_ready;
   logic             out_valid;
   logic [CW-1:0]    eq_cnt;
   logic             cnt_eq;
   logic             cnt_gt;
   logic             cnt_lt;
   logic             no_conflict;
   logic [POS_W-1:0] pos;

   int n_cmp = 0;
   int n_err = 0;
   int n_res = 0;
   int n_res_base;

   crib_matcher #(.WIDTH(WIDTH), .DEPTH(DEPTH), .POS_W(POS_W)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .thresh(thresh), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .eq_cnt(eq_cnt), .cnt_eq(cnt_eq), .cnt_gt(cnt_gt),
      .cnt_lt(cnt_lt), .no_conflict(no_conflict), .pos(pos)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && out_valid === 1'b1) n_res++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_res(input string tag, input int eq, input logic feq, input logic fgt,
                            input logic flt, input logic nc, input int p);
      check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".eq_cnt"}, 32'(eq_cnt), 32'(eq));
      check({tag, ".cnt_eq"}, 32'(cnt_eq), 32'(feq));
      check({tag, ".cnt_gt"}, 32'(cnt_gt), 32'(fgt));
      check({tag, ".cnt_lt"}, 32'(cnt_lt), 32'(flt));
      check({tag, ".no_conflict"}, 32'(no_conflict), 32'(nc));
      check({tag, ".pos"}, 32'(pos), 32'(p));
   endtask

   task automatic load_crib(input logic [4:0] l0, input logic [4:0] l1,
                            input logic [4:0] l2, input logic [4:0] l3);
      logic [4:0] l [4];
      l = '{l0, l1, l2, l3};
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1;
         load_data  = l[i];
         @(negedge clk);
      end
      load_valid = 1'b0;
   endtask

   task automatic send(input logic [4:0] d, input logic [2:0] t);
      in_valid = 1'b1;
      in_data  = d;
      thresh   = t;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      logic [4:0] gap_letters [8];
      gap_letters = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd1, 5'd2, 5'd3};

      // Asynchronous reset asserted between clock edges.
      #12 rst_n = 1'b0;
      #1;
      check("rst.load_ready", 32'(load_ready), 32'd1);
      check("rst.in_ready", 32'(in_ready), 32'd0);
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.pos", 32'(pos), 32'd0);
      check("rst.eq_cnt", 32'(eq_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Exact match.
      load_crib(5'd7, 5'd4, 5'd11, 5'd11);
      check("load.load_ready", 32'(load_ready), 32'd0);
      check("load.in_ready", 32'(in_ready), 32'd1);
      send(5'd7, 3'd4);
      send(5'd4, 3'd4);
      send(5'd11, 3'd4);
      check("fill.no_result", 32'(out_valid), 32'd0);
      send(5'd11, 3'd4);
      check_res("exact", 4, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      @(negedge clk);
      check("exact.pulse_end", 32'(out_valid), 32'd0);
      check("exact.hold", 32'(eq_cnt), 32'd4);

      // Reset mid-stream, asserted between edges.
      #3 rst_n = 1'b0;
      #1;
      check("rst2.load_ready", 32'(load_ready), 32'd1);
      check("rst2.in_ready", 32'(in_ready), 32'd0);
      check("rst2.eq_cnt", 32'(eq_cnt), 32'd0);
      check("rst2.cnt_eq", 32'(cnt_eq), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Sliding with no conflict.
      load_crib(5'd7, 5'd4, 5'd11, 5'd11);
      send(5'd1, 3'd1);
      send(5'd2, 3'd1);
      send(5'd3, 3'd1);
      send(5'd5, 3'd1);
      check_res("slide0", 0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
      send(5'd9, 3'd1);
      check_res("slide1", 0, 1'b0, 1'b0, 1'b1, 1'b1, 1);

      // Partial match, ordering and latched threshold.
      do_clear();
      load_crib(5'd0, 5'd1, 5'd2, 5'd3);
      send(5'd0, 3'd1);
      send(5'd9, 3'd1);
      send(5'd2, 3'd1);
      send(5'd9, 3'd1);
      check_res("part_gt", 2, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      thresh = 3'd0;
      @(negedge clk);
      check("part.thresh_latched", 32'(cnt_gt), 32'd1);
      send(5'd3, 3'd1);
      check_res("part_eq", 1, 1'b1, 1'b0, 1'b0, 1'b0, 1);

      // CLEAR with a letter in the cycle right after a result.
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 5'd0;
      #1;
      check("clear.pulse_kept", 32'(out_valid), 32'd1);
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b0;
      check("clear.dropped", 32'(out_valid), 32'd0);
      check("clear.load_ready", 32'(load_ready), 32'd1);
      check("clear.in_ready", 32'(in_ready), 32'd0);
      check("clear.eq_hold", 32'(eq_cnt), 32'd1);
      check("clear.pos_hold", 32'(pos), 32'd1);

      load_crib(5'd0, 5'd1, 5'd2, 5'd3);
      send(5'd0, 3'd3);
      send(5'd9, 3'd3);
      send(5'd2, 3'd3);
      send(5'd9, 3'd3);
      check_res("part_lt", 2, 1'b0, 1'b0, 1'b1, 1'b0, 0);

      // Handshake gaps with stray crib loads during RUN.
      do_clear();
      load_crib(5'd0, 5'd1, 5'd2, 5'd3);
      n_res_base = n_res;
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(0, 2)) begin
            load_valid = 1'b1;
            load_data  = 5'd31;
            in_valid   = 1'b0;
            @(negedge clk);
         end
         load_valid = 1'(i % 2);
         load_data  = 5'd31;
         send(gap_letters[i], 3'd4);
      end
      load_valid = 1'b0;
      check_res("gaps", 4, 1'b1, 1'b0, 1'b0, 1'b0, 4);
      @(negedge clk);
      #1;
      check("gaps.result_count", 32'(n_res - n_res_base), 32'd5);

      // POS saturation with a 3-bit position.
      @(negedge clk);
      do_clear();
      load_crib(5'd0, 5'd1, 5'd2, 5'd3);
      send(5'd25, 3'd0);
      send(5'd25, 3'd0);
      send(5'd25, 3'd0);
      for (int k = 0; k < 9; k++) begin
         send(5'd25, 3'd0);
         check($sformatf("sat%0d.out_valid", k), 32'(out_valid), 32'd1);
         check($sformatf("sat%0d.pos", k), 32'(pos), 32'((k < 7) ? k : 7));
      end
      check("sat.no_conflict", 32'(no_conflict), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
